fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end for the pipelined RISC-V core: owns the fetch PC, issues word reads to instruction memory over a request/grant handshake, and buffers returned words with their PCs in a small prefetch queue. It sits directly upstream of the decode pipeline register and delivers `instr`/`instr_pc` with a valid/ready handshake. It absorbs decode stalls and taken-branch/jump redirects, discarding responses still in flight from the wrong path.

## Interface
- `DEPTH`, 2: prefetch queue entries and maximum in-flight requests; power of two, ≥2.
- `RESET_PC`, 32'h00400000: fetch address after reset (text segment).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low.
- `imem_req`  out  1  read request valid.
- `imem_addr`  out  32  word-aligned read address; equals the fetch PC.
- `imem_gnt`  in  1  request accepted this cycle (`imem_req & imem_gnt`).
- `imem_rvalid`  in  1  read data valid; responses return in request order, at most one per cycle, ≥1 cycle after grant.
- `imem_rdata`  in  32  read data.
- `redirect`  in  1  taken branch/jump; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] forced to 0.
- `instr_valid`  out  1  queue head holds a returned instruction.
- `instr`  out  32  head instruction; 32'h00000013 (NOP) when `instr_valid`=0.
- `instr_pc`  out  32  PC of head instruction; 0 when `instr_valid`=0.
- `instr_pcplus4`  out  32  `instr_pc`+4; 0 when `instr_valid`=0.
- `instr_ready`  in  1  decode accepts head this cycle.

## Operation
- State: fetch PC `fpc`; circular queue of `DEPTH` entries {pc, data, filled}; pointers `rd_ptr`, `res_ptr` (next slot to reserve), `fill_ptr` (next slot to fill); `reserved` count (0..DEPTH); `discard` count (0..DEPTH).
- Credit: `imem_req` = rst deasserted & !`redirect` & (`reserved` + `discard` − pop < `DEPTH`), pop = `instr_valid & instr_ready`.
- Grant: reserve slot at `res_ptr` with pc=`fpc`, filled=0; `res_ptr`++, `reserved`++, `fpc` += 4 (mod 2^32, wraps).
- Response: if `discard`>0, drop data, `discard`−−; else write `imem_rdata` to slot `fill_ptr`, filled=1, `fill_ptr`++.
- Pop: `rd_ptr`++, `reserved`−−, clear filled. Grant, response and pop may all occur in one cycle; counters apply net change.
- Redirect (highest priority): `fpc` ← `redirect_pc`; all slots cleared, pointers reset to 0, `reserved` ← 0; `discard` ← (`discard` + reserved-but-unfilled slots − response dropped this cycle if counted). A response arriving in the redirect cycle is dropped. Pop in redirect cycle is ignored (head flushed regardless of `instr_ready`).
- `imem_req`/`imem_addr` may change without a grant only in a redirect cycle; otherwise a pending request holds until granted.
- `imem_rvalid` with no outstanding request: ignored (protocol error, no state change).

## Timing
- Reset (`rst`=0, async): `fpc`=`RESET_PC`, queue empty, counts 0; `imem_req`=0, `instr_valid`=0, `instr`=NOP, `instr_pc`=0, `instr_pcplus4`=0. First request with `imem_addr`=`RESET_PC` in the first cycle after release.
- Latency: grant in cycle t, rvalid in t+1 → `instr_valid`=1 in t+2 (registered fill; no combinational rdata→instr path).
- Throughput: with 1-cycle memory, constant grant and `instr_ready`=1, one instruction per cycle at `DEPTH`=2.
- Redirect in cycle t: `imem_req`=0 in t; `imem_addr`=`redirect_pc` in t+1; first new-path `instr_valid` no earlier than t+3.
- Reset asserted mid-operation: all state cleared immediately; in-flight responses after release are not discarded (memory must be reset together).

## Test plan
- Reset release, `imem_gnt`=1, 1-cycle memory returning addr^32'hA5A5A5A5, `instr_ready`=1 → `instr_pc` 0x00400000, 0x00400004, 0x00400008… on consecutive cycles from cycle 2, `instr_pcplus4`=pc+4.
- `instr_ready`=0 for 6 cycles → exactly 2 requests granted, `imem_req` drops, head holds pc 0x00400000; release → 0x00400000, 0x00400004, 0x00400008 in order, none lost.
- Two requests in flight, `redirect`=1 with `redirect_pc`=0x00400100 → both stale responses dropped, next `instr_pc`=0x00400100, no old-path instruction ever valid.
- `redirect` coincident with `imem_rvalid` and `instr_ready` → that response dropped, `instr_valid`=0 next cycle, `discard` accounts for remaining in-flight request only.
- `imem_gnt` randomly 0 for 1–3 cycles, memory latency 1–3 cycles → `imem_addr` stable while ungranted, output PC sequence strictly +4, in-flight never exceeds 2.
- Async `rst` low mid-stream (between edges) → outputs reset immediately: `instr_valid`=0, `instr`=32'h00000013; after release first `imem_addr`=0x00400000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word reads over a
// request/grant handshake and buffers returned words in a small prefetch queue.
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        instr_ready
);

    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]      fpc;
    logic [31:0]      slot_pc   [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] filled;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] res_ptr;
    logic [PW-1:0] fill_ptr;

    // reserved: slots owned by the current path (filled or awaiting data)
    // pending:  reserved slots still awaiting data
    // discard:  in-flight responses that belong to a flushed path
    logic [CW-1:0] reserved;
    logic [CW-1:0] pending;
    logic [CW-1:0] discard;

    logic        pop;
    logic        grant;
    logic        resp;
    logic        drop;
    logic        fill;
    logic [CW:0] occupancy;

    always_comb begin
        instr_valid   = filled[rd_ptr];
        pop           = instr_valid & instr_ready;
        occupancy     = {1'b0, reserved} + {1'b0, discard} - {{CW{1'b0}}, pop};
        imem_req      = rst & ~redirect & (occupancy < (CW + 1)'(DEPTH));
        imem_addr     = fpc;
        grant         = imem_req & imem_gnt;
        // Responses with nothing outstanding are protocol errors and ignored.
        resp          = imem_rvalid & ((discard != '0) | (pending != '0));
        drop          = resp & ((discard != '0) | redirect);
        fill          = resp & ~drop;
        instr         = instr_valid ? slot_data[rd_ptr] : NOP;
        instr_pc      = instr_valid ? slot_pc[rd_ptr] : '0;
        instr_pcplus4 = instr_valid ? slot_pc[rd_ptr] + 32'd4 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc      <= RESET_PC;
            filled   <= '0;
            rd_ptr   <= '0;
            res_ptr  <= '0;
            fill_ptr <= '0;
            reserved <= '0;
            pending  <= '0;
            discard  <= '0;
        end else if (redirect) begin
            fpc      <= redirect_pc & 32'hFFFF_FFFC;
            filled   <= '0;
            rd_ptr   <= '0;
            res_ptr  <= '0;
            fill_ptr <= '0;
            reserved <= '0;
            pending  <= '0;
            // Every unfilled slot becomes a response to throw away, less the
            // one that arrives (and is dropped) in this very cycle.
            discard  <= discard + pending - CW'(resp);
        end else begin
            // A grant into the slot being popped is safe: both clear filled.
            if (grant) begin
                filled[res_ptr] <= 1'b0;
                res_ptr         <= res_ptr + PW'(1);
                fpc             <= fpc + 32'd4;
            end
            if (fill) begin
                filled[fill_ptr] <= 1'b1;
                fill_ptr         <= fill_ptr + PW'(1);
            end
            if (pop) begin
                filled[rd_ptr] <= 1'b0;
                rd_ptr         <= rd_ptr + PW'(1);
            end
            reserved <= reserved + CW'(grant) - CW'(pop);
            pending  <= pending + CW'(grant) - CW'(fill);
            discard  <= discard - CW'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            slot_pc[res_ptr] <= fpc;
        end
        if (fill) begin
            slot_data[fill_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order random-latency memory and a
// queue-level reference model of fetch ordering, flushes and decode delivery.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] MASK     = 32'hA5A5_A5A5;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        instr_ready;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: next fetch address, words returned on the live path
    // awaiting decode, and outstanding reads in order with a flushed-path flag.
    logic [31:0] m_fpc;
    logic [31:0] rq[$];
    logic [31:0] oq_addr[$];
    bit          oq_stale[$];
    int          oq_due[$];
    int          cyc;
    int          last_due;
    int          lat_lo;
    int          lat_hi;
    bit          prev_hold;
    logic [31:0] prev_addr;

    task automatic model_clear();
        m_fpc = RESET_PC;
        rq.delete();
        oq_addr.delete();
        oq_stale.delete();
        oq_due.delete();
        last_due  = 0;
        prev_hold = 1'b0;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit gnt);
        bit          rv;
        bit          pop;
        bit          ereq;
        bit          st;
        int          occ;
        int          due;
        logic [31:0] a;
        @(negedge clk);
        cyc++;
        rv          = (oq_addr.size() > 0) && (oq_due[0] <= cyc);
        redirect    = redir;
        redirect_pc = rpc;
        instr_ready = rdy;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rv ? (oq_addr[0] ^ MASK) : $urandom;
        #1;
        pop  = (rq.size() > 0) && rdy;
        occ  = rq.size() + oq_addr.size() - (pop ? 1 : 0);
        ereq = !redir && (occ < DEPTH);
        check("imem_req", imem_req, ereq);
        check("imem_addr", imem_addr, m_fpc);
        if (prev_hold) check("addr_hold_ungranted", imem_addr, prev_addr);
        if (rq.size() > 0) begin
            check("instr_valid", instr_valid, 1);
            check("instr", instr, rq[0] ^ MASK);
            check("instr_pc", instr_pc, rq[0]);
            check("instr_pcplus4", instr_pcplus4, rq[0] + 32'd4);
        end else begin
            check("instr_valid_idle", instr_valid, 0);
            check("instr_nop", instr, NOP);
            check("instr_pc_idle", instr_pc, 0);
            check("instr_pcplus4_idle", instr_pcplus4, 0);
        end
        prev_hold = imem_req && !gnt;
        prev_addr = imem_addr;
        st = 1'b1;
        a  = '0;
        if (rv) begin
            a  = oq_addr.pop_front();
            st = oq_stale.pop_front();
            void'(oq_due.pop_front());
        end
        if (redir) begin
            rq.delete();
            foreach (oq_stale[i]) oq_stale[i] = 1'b1;
            m_fpc = rpc & 32'hFFFF_FFFC;
        end else begin
            if (pop) void'(rq.pop_front());
            if (rv && !st) rq.push_back(a);
            if (imem_req && gnt) begin
                due = cyc + $urandom_range(lat_hi, lat_lo);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                oq_addr.push_back(m_fpc);
                oq_stale.push_back(1'b0);
                oq_due.push_back(due);
                m_fpc = m_fpc + 32'd4;
            end
        end
        check("inflight_le_depth", 32'(oq_addr.size() <= DEPTH), 1);
    endtask

    // Asserts reset between edges, checks the outputs react immediately,
    // then releases it between edges so the next cycle is the first live one.
    task automatic reset_seq();
        @(posedge clk);
        #3;
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        #1;
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_instr_pcplus4", instr_pcplus4, 0);
        check("rst_imem_req", imem_req, 0);
        model_clear();
        repeat (2) @(posedge clk);
        check("rst_hold_req", imem_req, 0);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cyc = 0;
        lat_lo = 1;
        lat_hi = 1;
        rst = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        model_clear();

        // Streaming at full rate with a one-cycle memory.
        reset_seq();
        for (int i = 0; i < 20; i++) begin
            step(0, '0, 1, 1);
            if (i == 2) check("first_valid_pc", instr_pc, RESET_PC);
            if (i == 5) check("stream_pc", instr_pc, RESET_PC + 32'd12);
        end

        // Decode stall: two grants then the request drops, head held.
        reset_seq();
        for (int i = 0; i < 8; i++) step(0, '0, 0, 1);
        check("stall_req_low", imem_req, 0);
        check("stall_head_pc", instr_pc, RESET_PC);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 1);

        // Redirect with two stale requests in flight.
        lat_lo = 3;
        lat_hi = 3;
        for (int i = 0; i < 10; i++) begin
            if (oq_addr.size() == DEPTH) break;
            step(0, '0, 1, 1);
        end
        check("two_inflight", oq_addr.size(), DEPTH);
        step(1, 32'h0040_0100, 1, 1);
        for (int i = 0; i < 14; i++) step(0, '0, 1, 1);

        // Redirect coinciding with a response and a pop.
        lat_lo = 1;
        lat_hi = 1;
        for (int i = 0; i < 6; i++) step(0, '0, 1, 1);
        check("coincident_rvalid", imem_rvalid, 1);
        step(1, 32'h0040_0200, 1, 1);
        step(0, '0, 1, 1);
        check("post_redirect_valid", instr_valid, 0);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 1);

        // Fetch PC wrap-around; low redirect bits ignored.
        step(1, 32'hFFFF_FFFA, 1, 1);
        for (int i = 0; i < 8; i++) step(0, '0, 1, 1);

        // Random grants, latency, stalls and redirects.
        lat_lo = 1;
        lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 3),
                 RESET_PC | ($urandom & 32'h0000_0FFF),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0));
        end

        // Reset mid-stream, then restart from RESET_PC.
        reset_seq();
        lat_lo = 1;
        lat_hi = 1;
        for (int i = 0; i < 10; i++) step(0, '0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
